// File: rtl/xosera_bus_master_if.sv
// Host request/response and Xosera register-bus signals for xosera_bus_master.
// Latency: none, this only bundles wires.
// Backpressure: req_valid_i/req_ready_o handshake; the bus side is timed by the master.
// Ports (signal names are from the bus master's point of view):
//   req_*  host request (valid/ready, rd_nwr, reg_num, 16-bit data)
//   rsp_*  completion pulse and 16-bit read data
//   bus_*  Xosera 8-bit register bus plus the interrupt input
//   intr_o host interrupt pulse
// Modports: master = bus master side, slave = host/Xosera side (bench).
interface xosera_bus_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_rd_nwr_i;
    logic [3:0]  req_reg_num_i;
    logic [15:0] req_data_i;
    logic        rsp_valid_o;
    logic [15:0] rsp_data_o;
    logic        bus_cs_n_o;
    logic        bus_rd_nwr_o;
    logic [3:0]  bus_reg_num_o;
    logic        bus_bytesel_o;
    logic [7:0]  bus_data_o;
    logic [7:0]  bus_data_i;
    logic        bus_intr_i;
    logic        intr_o;

    modport master (
        input  req_valid_i, req_rd_nwr_i, req_reg_num_i, req_data_i,
        input  bus_data_i, bus_intr_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
        output bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o,
        output intr_o
    );

    modport slave (
        output req_valid_i, req_rd_nwr_i, req_reg_num_i, req_data_i,
        output bus_data_i, bus_intr_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
        input  bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o,
        input  intr_o
    );
endinterface

// File: rtl/xosera_bus_master.sv
// Converts one 16-bit host register access into two timed Xosera byte cycles (high byte first).
// Latency: accept at edge 0, rsp_valid_o in cycle 2*(SETUP+STROBE+HOLD)+1, ready again one cycle later.
// Backpressure: req_ready_o is high only in IDLE; requests presented while busy wait for ready.
// Ports: clk, reset (synchronous, active high), bif (xosera_bus_master_if.master).
// Parameters: SETUP_CYC, STROBE_CYC, HOLD_CYC, each 1..15 cycles per byte phase.
// Optional feature macro XOSERA_BUS_MASTER_INTR_EN: when defined, bus_intr_i is
// synchronized (2 flops) and rising edges become one-cycle intr_o pulses; otherwise intr_o = 0.
module xosera_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                clk,
    input  logic                reset,
    xosera_bus_master_if.master bif
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 ||
        STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_param_chk
        $error("xosera_bus_master: SETUP_CYC/STROBE_CYC/HOLD_CYC must be in 1..15");
    end

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at 0.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;       // 0 = high byte, 1 = low byte
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_nwr_q, rd_nwr_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rbuf_q, rbuf_d;          // read bytes collected during the strobes

    // Registered outputs; their next values are derived from the next state so
    // every output reflects the current state with no combinational path.
    logic        ready_q, ready_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [15:0] rsp_dat_q, rsp_dat_d;
    logic        cs_n_q, cs_n_d;
    logic        bus_rd_nwr_q, bus_rd_nwr_d;
    logic [3:0]  bus_reg_q, bus_reg_d;
    logic        bytesel_q, bytesel_d;
    logic [7:0]  bus_dat_q, bus_dat_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rd_nwr_d  = rd_nwr_q;
        reg_num_d = reg_num_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bif.req_valid_i && ready_q) begin
                    rd_nwr_d  = bif.req_rd_nwr_i;
                    reg_num_d = bif.req_reg_num_i;
                    wdata_d   = bif.req_data_i;
                    rbuf_d    = 16'h0000;
                    phase_d   = 1'b0;
                    cnt_d     = SETUP_LD;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: Xosera read data is settled here.
                    if (rd_nwr_q) begin
                        if (phase_q) rbuf_d[7:0]  = bif.bus_data_i;
                        else         rbuf_d[15:8] = bif.bus_data_i;
                    end
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        cnt_d   = SETUP_LD;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = (state_d == ST_IDLE);
        rsp_vld_d = (state_d == ST_DONE);
        rsp_dat_d = rsp_dat_q;
        if (state_d == ST_DONE) begin
            rsp_dat_d = rd_nwr_d ? rbuf_d : 16'h0000;
        end

        // Bus is parked whenever no byte cycle is in progress.
        cs_n_d       = 1'b1;
        bus_rd_nwr_d = 1'b1;
        bus_reg_d    = 4'd0;
        bytesel_d    = 1'b0;
        bus_dat_d    = 8'h00;
        if (state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD) begin
            cs_n_d       = (state_d != ST_STROBE);
            bus_rd_nwr_d = rd_nwr_d;
            bus_reg_d    = reg_num_d;
            bytesel_d    = phase_d;
            if (!rd_nwr_d) begin
                bus_dat_d = phase_d ? wdata_d[7:0] : wdata_d[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            cnt_q        <= 4'd0;
            rd_nwr_q     <= 1'b1;
            reg_num_q    <= 4'd0;
            wdata_q      <= 16'h0000;
            rbuf_q       <= 16'h0000;
            ready_q      <= 1'b1;
            rsp_vld_q    <= 1'b0;
            rsp_dat_q    <= 16'h0000;
            cs_n_q       <= 1'b1;
            bus_rd_nwr_q <= 1'b1;
            bus_reg_q    <= 4'd0;
            bytesel_q    <= 1'b0;
            bus_dat_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            rd_nwr_q     <= rd_nwr_d;
            reg_num_q    <= reg_num_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            ready_q      <= ready_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_dat_q    <= rsp_dat_d;
            cs_n_q       <= cs_n_d;
            bus_rd_nwr_q <= bus_rd_nwr_d;
            bus_reg_q    <= bus_reg_d;
            bytesel_q    <= bytesel_d;
            bus_dat_q    <= bus_dat_d;
        end
    end

    assign bif.req_ready_o   = ready_q;
    assign bif.rsp_valid_o   = rsp_vld_q;
    assign bif.rsp_data_o    = rsp_dat_q;
    assign bif.bus_cs_n_o    = cs_n_q;
    assign bif.bus_rd_nwr_o  = bus_rd_nwr_q;
    assign bif.bus_reg_num_o = bus_reg_q;
    assign bif.bus_bytesel_o = bytesel_q;
    assign bif.bus_data_o    = bus_dat_q;

`ifdef XOSERA_BUS_MASTER_INTR_EN
    // bus_intr_i may come from another clock domain: two synchronizer flops,
    // then a rising-edge detect so a held level yields a single pulse.
    logic intr_s1_q, intr_s2_q, intr_prev_q, intr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            intr_s1_q   <= 1'b0;
            intr_s2_q   <= 1'b0;
            intr_prev_q <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            intr_s1_q   <= bif.bus_intr_i;
            intr_s2_q   <= intr_s1_q;
            intr_prev_q <= intr_s2_q;
            intr_q      <= intr_s2_q & ~intr_prev_q;
        end
    end

    assign bif.intr_o = intr_q;
`else
    logic unused_intr;
    assign unused_intr = bif.bus_intr_i;
    assign bif.intr_o  = 1'b0;
`endif

endmodule

// File: doc/xosera_bus_master.md
# xosera_bus_master

Synthesizable host-side bus master that drives the Xosera 8-bit register bus: `bus_cs_n`, `bus_rd_nwr`, `bus_reg_num`, `bus_bytesel` and `bus_data`. It sits directly upstream of `xosera_main`. It converts single 16-bit register read/write requests from an on-chip host (soft CPU, UART bridge, test sequencer) into two timed byte cycles, even/high byte first. The FPGA-internal host therefore never hand-times the bus.

## Interface
Parameters:
- `SETUP_CYC`, 1: cycles address/data are stable with `cs_n` high before the strobe (1..15)
- `STROBE_CYC`, 3: cycles `cs_n` is held low per byte (1..15)
- `HOLD_CYC`, 1: cycles address/data are held after `cs_n` rises (1..15)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, same clock as `xosera_main`
- `reset`  in  1  synchronous, active-high reset
- `req_valid_i`  in  1  host request valid
- `req_ready_o`  out  1  request accepted when `req_valid_i & req_ready_o` at a rising edge
- `req_rd_nwr_i`  in  1  1 = read, 0 = write
- `req_reg_num_i`  in  4  Xosera register number
- `req_data_i`  in  16  write data; ignored for reads
- `rsp_valid_o`  out  1  one-cycle completion pulse
- `rsp_data_o`  out  16  read data (high byte from `bytesel`=0); 0x0000 after a write
- `bus_cs_n_o`  out  1  chip select, active low
- `bus_rd_nwr_o`  out  1  bus direction
- `bus_reg_num_o`  out  4  register number
- `bus_bytesel_o`  out  1  0 = even/high byte, 1 = odd/low byte
- `bus_data_o`  out  8  write byte
- `bus_data_i`  in  8  read byte from Xosera
- `bus_intr_i`  in  1  Xosera interrupt output
- `intr_o`  out  1  host interrupt pulse (see Configuration)

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE, plus a phase bit (0 = high byte, 1 = low byte) and a 4-bit down-counter.
- IDLE:
  - `req_ready_o`=1.
  - On acceptance, latch rd_nwr, reg_num and data; phase←0; go to SETUP with counter=SETUP_CYC-1.
- SETUP:
  - `cs_n`=1; reg_num, rd_nwr and `bytesel`=phase are driven.
  - `bus_data_o` = data[15:8] (phase 0) or data[7:0] (phase 1) for writes, 0x00 for reads.
- STROBE: same signals with `cs_n`=0. For reads, `bus_data_i` is sampled on the last STROBE cycle into rsp_data[15:8] (phase 0) or rsp_data[7:0] (phase 1).
- HOLD: `cs_n`=1; all other bus outputs unchanged from STROBE.
- Counter transitions: each state lasts its parameter count of cycles. HOLD exit goes to SETUP with phase←1 if phase=0, else to DONE.
- DONE: one cycle; `rsp_valid_o`=1, `req_ready_o`=0; `rsp_data_o` is valid in this cycle and holds until the next DONE. Next state is IDLE.
- Writes: `rsp_data_o` is forced to 0x0000.
- IDLE bus outputs: `cs_n`=1, `rd_nwr`=1, reg_num=0, `bytesel`=0, data=0x00.
- `req_valid_i` while busy is ignored; the host must hold its request until ready.

## Timing
- Reset values: `req_ready_o`=1 (first cycle after reset deasserts), `rsp_valid_o`=0, `rsp_data_o`=0x0000, `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_reg_num_o`=0, `bus_bytesel_o`=0, `bus_data_o`=0x00, `intr_o`=0.
- All outputs are registered.
- Latency: acceptance edge at cycle 0 → SETUP starts cycle 1 → DONE at cycle 2·(S+T+H)+1 (defaults: 11). `req_ready_o` is high again at cycle 2·(S+T+H)+2.
- Throughput: one request per 2·(S+T+H)+2 cycles with `req_valid_i` held high.
- Address/data change only on SETUP entry, so they are stable ≥SETUP_CYC before `cs_n` falls and ≥HOLD_CYC after it rises.
- Reset mid-operation: next cycle returns to IDLE with reset values, `cs_n`=1, no `rsp_valid_o`, and no partial retry.
- Counter width is 4 bits; parameters outside 1..15 are illegal (checked by an elaboration assertion).

## Configuration
- Macro `XOSERA_BUS_MASTER_INTR_EN`.
- Defined:
  - `bus_intr_i` passes through a 2-flop synchronizer, then a rising-edge detector.
  - `intr_o` is a one-cycle pulse 3 cycles after `bus_intr_i` rises.
  - A level held high yields exactly one pulse.
- Undefined: `bus_intr_i` is ignored and `intr_o` is constant 0; no synchronizer flops are instantiated.

## Test plan
- Write reg 3 = 0x1234, defaults → two strobes, each with `cs_n` low 3 cycles. First strobe: `bytesel`=0, data 0x12. Second strobe: `bytesel`=1, data 0x34. `rsp_valid_o` at cycle 11, `rsp_data_o`=0x0000.
- Read reg 5; model returns 0xAB on `bytesel`=0 and 0xCD on `bytesel`=1 → `rsp_data_o`=0xABCD with `rsp_valid_o`; `bus_data_o` stays 0x00.
- Back-to-back write then read with `req_valid_i` held → second request accepted at cycle 12. `cs_n` high ≥ SETUP+HOLD between strobes; requests never overlap.
- `reset` pulsed during phase-1 STROBE → `cs_n`=1 next cycle, no `rsp_valid_o`, `req_ready_o`=1 after release.
- `SETUP_CYC`=2, `STROBE_CYC`=1, `HOLD_CYC`=3 → per-byte durations match exactly; DONE at cycle 13.
- With `XOSERA_BUS_MASTER_INTR_EN`, `bus_intr_i` rises and stays high 10 cycles → single `intr_o` pulse 3 cycles after the rise. Without the macro, `intr_o` stays 0.
